// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file: synchronised serial inputs, write and read-back frames.
module spi_regfile #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         sdi,
    input  logic                         cs,
    output logic                         sdo,
    output logic                         sdo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int unsigned CMD_W   = 1 + ADDR_W;
    localparam int unsigned FRAME_W = CMD_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_CHECK, S_WAIT_CS
    } state_t;

    state_t                   state, state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync, sdi_sync, cs_sync;
    logic                     sclk_prev, cs_prev;
    logic [CNT_W-1:0]         cnt, cnt_d, cnt_inc;
    logic [CMD_W-2:0]         cmd_sr, cmd_d;
    logic [CMD_W-1:0]         cmd_shift;
    logic [DATA_W-1:0]        data_sr, data_d;
    logic [DATA_W-1:0]        rd_sr, rd_d, rd_sel;
    logic                     is_wr, is_wr_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     sdo_d, sdo_oe_d, wr_pulse_d, frame_err_d, reg_we;
    logic [ADDR_W-1:0]        wr_addr_d;

    logic sclk_s, sdi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cmd_shift = {cmd_sr, sdi_s};
    assign cnt_inc   = (cnt == CNT_W'(FRAME_W + 1)) ? cnt : cnt + CNT_W'(1);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
    endfunction

    // Input synchronisers; cs resets low so a chip select held at reset release is waited out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Read mux for the address being completed in the current command bit
    always_comb begin
        rd_sel = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (cmd_shift[ADDR_W-1:0] == ADDR_W'(k)) rd_sel = regs[k*DATA_W +: DATA_W];
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cmd_d       = cmd_sr;
        data_d      = data_sr;
        rd_d        = rd_sr;
        is_wr_d     = is_wr;
        addr_d      = addr_q;
        sdo_d       = sdo;
        sdo_oe_d    = sdo_oe;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr;
        frame_err_d = 1'b0;
        reg_we      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    cmd_d   = '0;
                    data_d  = '0;
                end else if (!cs_s) begin
                    state_d = S_WAIT_CS;
                end
            end
            S_CMD: begin
                if (cs_rise) begin
                    state_d  = S_CHECK;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                end else if (sclk_rise) begin
                    cmd_d = cmd_shift[CMD_W-2:0];
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(CMD_W)) begin
                        state_d  = S_DATA;
                        is_wr_d  = cmd_shift[CMD_W-1];
                        addr_d   = cmd_shift[ADDR_W-1:0];
                        sdo_oe_d = ~cmd_shift[CMD_W-1];
                        rd_d     = (!cmd_shift[CMD_W-1] && addr_ok(cmd_shift[ADDR_W-1:0])) ? rd_sel : '0;
                    end
                end
            end
            S_DATA: begin
                if (cs_rise) begin
                    state_d  = S_CHECK;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        cnt_d = cnt_inc;
                        if (is_wr && cnt < CNT_W'(FRAME_W)) data_d = {data_sr[DATA_W-2:0], sdi_s};
                    end
                    if (sclk_fall && !is_wr) begin
                        sdo_d = rd_sr[DATA_W-1];
                        rd_d  = {rd_sr[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (cnt == CNT_W'(FRAME_W) && addr_ok(addr_q)) begin
                    if (is_wr) begin
                        reg_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = addr_q;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            S_WAIT_CS: begin
                if (cs_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            is_wr     <= 1'b0;
            addr_q    <= '0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            regs      <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cmd_sr    <= cmd_d;
            data_sr   <= data_d;
            rd_sr     <= rd_d;
            is_wr     <= is_wr_d;
            addr_q    <= addr_d;
            sdo       <= sdo_d;
            sdo_oe    <= sdo_oe_d;
            wr_pulse  <= wr_pulse_d;
            wr_addr   <= wr_addr_d;
            frame_err <= frame_err_d;
            if (reg_we) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (addr_q == ADDR_W'(k)) regs[k*DATA_W +: DATA_W] <= data_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile.sv
// Randomised bench for spi_regfile against a frame-level register model.
module tb_spi_regfile;

    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CMD_W       = 1 + ADDR_W;
    localparam int unsigned FRAME_W     = CMD_W + DATA_W;
    localparam int          HALF        = 8;
    localparam int          GAP         = 10;
    localparam int          MIN_GAP     = SYNC_STAGES + 2;

    logic clk = 1'b0;
    logic rst_n, sclk, sdi, cs;
    logic sdo, sdo_oe, wr_pulse, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic [ADDR_W-1:0] wr_addr;

    always #5 clk = ~clk;

    spi_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs(cs),
        .sdo(sdo), .sdo_oe(sdo_oe), .regs(regs), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and a watch for register changes outside a write commit
    int wr_seen = 0, err_seen = 0, reg_glitch = 0;
    logic [63:0] prev_regs = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_pulse) wr_seen++;
            if (frame_err) err_seen++;
            if (regs !== prev_regs && !wr_pulse) reg_glitch++;
        end
        prev_regs = regs;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Reference: register array updated per completed frame
    logic [DATA_W-1:0] mregs [NUM_REGS];

    function automatic logic [63:0] model_flat();
        logic [63:0] f = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) f[k*DATA_W +: DATA_W] = mregs[k];
        return f;
    endfunction

    function automatic void model_apply(input logic [15:0] word, input int nbits,
                                        output int e_err, output int e_wr,
                                        output logic [DATA_W-1:0] e_rd);
        logic       is_w = word[15];
        int         a    = int'(word[14:8]);
        logic       ok   = (nbits == int'(FRAME_W)) && (a < int'(NUM_REGS));
        e_err = ok ? 0 : 1;
        e_wr  = (ok && is_w) ? 1 : 0;
        e_rd  = (a < int'(NUM_REGS)) ? mregs[a] : '0;
        if (ok && is_w) mregs[a] = word[7:0];
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Mode-0 master: drive on sclk low, sample sdo just before each rising edge
    task automatic spi_xfer(input logic [15:0] word, input int nbits, input bit raise_cs,
                            output logic [DATA_W-1:0] rd, output logic oe_seen);
        rd = '0;
        oe_seen = 1'b0;
        cs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < int'(FRAME_W)) ? word[int'(FRAME_W) - 1 - i] : 1'b1;
            wait_clks(HALF);
            if (i == int'(CMD_W)) oe_seen = sdo_oe;
            if (i >= int'(CMD_W) && i < int'(FRAME_W)) rd = {rd[DATA_W-2:0], sdo};
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        if (raise_cs) begin
            wait_clks(HALF);
            cs = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [15:0] word, input int nbits);
        int e_err, e_wr, w0, f0;
        logic [DATA_W-1:0] e_rd, rd;
        logic oe;
        model_apply(word, nbits, e_err, e_wr, e_rd);
        w0 = wr_seen;
        f0 = err_seen;
        spi_xfer(word, nbits, 1'b1, rd, oe);
        wait_clks(GAP);
        check("frame_err_count", 64'(err_seen - f0), 64'(e_err));
        check("wr_pulse_count", 64'(wr_seen - w0), 64'(e_wr));
        if (e_wr == 1) check("wr_addr", 64'(wr_addr), 64'(word[14:8]));
        check("regs", regs, model_flat());
        if (!word[15] && nbits >= int'(FRAME_W)) check("read_data", 64'(rd), 64'(e_rd));
        if (nbits > int'(CMD_W)) check("sdo_oe_data_phase", 64'(oe), 64'(!word[15]));
        check("sdo_oe_idle", 64'(sdo_oe), 64'(0));
        check("sdo_idle", 64'(sdo), 64'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic oe;
        int w0, f0, e_err, e_wr, nb;
        logic [DATA_W-1:0] e_rd;
        logic [15:0] w;

        for (int k = 0; k < int'(NUM_REGS); k++) mregs[k] = '0;
        rst_n = 1'b0; sclk = 1'b0; sdi = 1'b0; cs = 1'b1;
        wait_clks(4);
        check("rst_regs", regs, 64'(0));
        check("rst_sdo", 64'(sdo), 64'(0));
        check("rst_sdo_oe", 64'(sdo_oe), 64'(0));
        check("rst_wr_pulse", 64'(wr_pulse), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        rst_n = 1'b1;
        wait_clks(GAP);

        run_frame(16'h83A5, 16);
        check("reg3_a5", 64'(regs[31:24]), 64'hA5);
        run_frame(16'h0300, 16);
        run_frame(16'h81FF, 12);
        run_frame(16'h895A, 16);
        run_frame(16'h0900, 16);
        run_frame(16'h8255, 17);

        // back-to-back writes with minimum chip-select gap
        w0 = wr_seen;
        f0 = err_seen;
        model_apply(16'h8011, 16, e_err, e_wr, e_rd);
        model_apply(16'h8722, 16, e_err, e_wr, e_rd);
        spi_xfer(16'h8011, 16, 1'b1, rd, oe);
        wait_clks(MIN_GAP);
        spi_xfer(16'h8722, 16, 1'b1, rd, oe);
        wait_clks(GAP);
        check("b2b_wr_count", 64'(wr_seen - w0), 64'(2));
        check("b2b_err_count", 64'(err_seen - f0), 64'(0));
        check("b2b_reg0", 64'(regs[7:0]), 64'h11);
        check("b2b_reg7", 64'(regs[63:56]), 64'h22);
        check("b2b_regs", regs, model_flat());

        // reset mid-frame, released while cs is still held low
        spi_xfer(16'h84C3, 10, 1'b0, rd, oe);
        rst_n = 1'b0;
        wait_clks(3);
        for (int k = 0; k < int'(NUM_REGS); k++) mregs[k] = '0;
        check("midrst_regs", regs, 64'(0));
        check("midrst_sdo_oe", 64'(sdo_oe), 64'(0));
        check("midrst_sdo", 64'(sdo), 64'(0));
        check("midrst_wr_addr", 64'(wr_addr), 64'(0));
        f0 = err_seen;
        rst_n = 1'b1;
        wait_clks(GAP);
        cs = 1'b1;
        wait_clks(GAP);
        check("midrst_no_err", 64'(err_seen - f0), 64'(0));
        run_frame(16'h84C3, 16);
        check("midrst_reg4", 64'(regs[39:32]), 64'hC3);

        // randomised frames: mixed direction, some bad addresses and lengths
        for (int n = 0; n < 30; n++) begin
            w[15]   = ($urandom_range(0, 2) != 0);
            w[14:8] = 7'($urandom_range(0, 9));
            w[7:0]  = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       nb = int'($urandom_range(1, 15));
                1:       nb = 17;
                default: nb = 16;
            endcase
            run_frame(w, nb);
        end

        check("regs_stable", 64'(reg_glitch), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
